// File: rtl/spi_receiver_if.sv
// SPI receive-side bus: the stimulus generator drives ss/sclk/miso (master),
// and spi_receiver returns the received word and frame status (slave).
interface spi_receiver_if #(
    parameter int unsigned bitcount = 16
) ();
    logic                ss;
    logic                sclk;
    logic                miso;
    logic [bitcount-1:0] data;
    logic                complete;
    logic                error;
    logic                busy;

    modport master (
        output ss, sclk, miso,
        input  data, complete, error, busy
    );

    modport slave (
        input  ss, sclk, miso,
        output data, complete, error, busy
    );
endinterface

// File: rtl/spi_receiver.sv
// Deserialising SPI receiver: samples miso on the configured sclk edge while ss is
// active and reports the word plus complete/error once the frame closes.
module spi_receiver #(
    parameter int unsigned bitcount      = 16,
    parameter bit          ss_polarity   = 1'b0,
    parameter bit          sclk_polarity = 1'b0,
    parameter bit          sclk_phase    = 1'b0,
    parameter bit          msb_first     = 1'b1
) (
    input logic           clock,
    input logic           reset,
    spi_receiver_if.slave bus
);
    localparam int unsigned   CW       = $clog2(bitcount + 1) + 1;
    localparam logic [CW-1:0] CNT_FULL = CW'(bitcount);
    localparam logic [CW-1:0] CNT_SAT  = CW'(bitcount + 1);

    typedef enum logic {
        IDLE,
        ACTIVE
    } state_t;

    state_t              state_q, state_d;
    logic                sclk_q, sclk_d;
    logic [bitcount-1:0] shift_q, shift_d;
    logic [bitcount-1:0] data_q, data_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                complete_q, complete_d;
    logic                error_q, error_d;
    logic                busy_q, busy_d;

    logic                ss_act;
    logic                sclk_n;
    logic                rise;
    logic                fall;
    logic                sample_edge;
    logic [bitcount-1:0] shift_src;
    logic [bitcount-1:0] shifted;

    assign ss_act      = ss_polarity ? bus.ss : ~bus.ss;
    assign sclk_n      = sclk_polarity ? ~bus.sclk : bus.sclk;
    assign rise        = sclk_n & ~sclk_q;
    assign fall        = ~sclk_n & sclk_q;
    assign sample_edge = (sclk_phase ? fall : rise) & ss_act;

    // An edge in the activation cycle shifts into a freshly cleared register.
    assign shift_src = (state_q == IDLE) ? '0 : shift_q;
    assign shifted   = msb_first ? {shift_src[bitcount-2:0], bus.miso}
                                 : {bus.miso, shift_src[bitcount-1:1]};

    always_comb begin
        state_d    = state_q;
        sclk_d     = sclk_n;
        shift_d    = shift_q;
        data_d     = data_q;
        cnt_d      = cnt_q;
        complete_d = complete_q;
        error_d    = error_q;
        case (state_q)
            IDLE: begin
                if (ss_act) begin
                    state_d    = ACTIVE;
                    complete_d = 1'b0;
                    error_d    = 1'b0;
                    shift_d    = '0;
                    cnt_d      = '0;
                    if (sample_edge) begin
                        shift_d = shifted;
                        cnt_d   = CW'(1);
                    end
                end
            end
            ACTIVE: begin
                if (!ss_act) begin
                    state_d = IDLE;
                    if (cnt_q == CNT_FULL) begin
                        data_d     = shift_q;
                        complete_d = 1'b1;
                    end else begin
                        error_d = 1'b1;
                    end
                end else if (sample_edge) begin
                    shift_d = shifted;
                    // Saturate one past full so any overrun stays distinguishable.
                    if (cnt_q != CNT_SAT) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == ACTIVE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            sclk_q     <= 1'b0;
            shift_q    <= '0;
            data_q     <= '0;
            cnt_q      <= '0;
            complete_q <= 1'b0;
            error_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            sclk_q     <= sclk_d;
            shift_q    <= shift_d;
            data_q     <= data_d;
            cnt_q      <= cnt_d;
            complete_q <= complete_d;
            error_q    <= error_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.data     = data_q;
    assign bus.complete = complete_q;
    assign bus.error    = error_q;
    assign bus.busy     = busy_q;
endmodule
